fir_output_requantizer: RTL
===========================

// Module: fir_output_requantizer
// PURPOSE
//  Receive side of the FIR filter output interface. Takes the full-precision 48-bit accumulator
//  stream (Data/DataValid, no backpressure) and requantizes each sample to OutWidth signed bits:
//  arithmetic right shift, convergent rounding, then saturation. Results are buffered in a FIFO
//  and presented downstream on a valid/ready handshake. Sits between the filter and sample sinks.
// PARAMETERS
//  InWidth    48  input accumulator width (signed, two's complement)
//  OutWidth   18  output sample width (signed)
//  Shift      17  right-shift amount, 0 <= Shift < InWidth; 0 disables rounding
//  FifoDepth  8   output FIFO entries; power of 2, >= 2
// PORTS
//  Clk_i          in   1               single clock, all logic on posedge
//  Rstn_i         in   1               synchronous reset, active-low
//  Data_i         in   InWidth         filter accumulator sample (signed)
//  DataValid_i    in   1               Data_i valid this cycle; no ready, always accepted
//  Data_o         out  OutWidth        requantized sample at FIFO head
//  DataValid_o    out  1               FIFO non-empty
//  DataReady_i    in   1               sink accepts; pop on DataValid_o & DataReady_i
//  Overflow_o     out  1               sticky: a sample was saturated
//  Dropped_o      out  1               sticky: a sample was lost because the FIFO was full
//  FlagClr_i      in   1               clears Overflow_o and Dropped_o
//  Level_o        out  $clog2(D)+1     current FIFO occupancy
// BEHAVIOUR
//  - Reset (Rstn_i=0 at a posedge): pipeline valid bits, FIFO pointers, Level_o, Overflow_o and
//    Dropped_o go to 0; DataValid_o=0. Data registers are not reset. In-flight samples are lost.
//  - Stage 1 (posedge after DataValid_i): q = Data_i >>> Shift, f = Data_i[Shift-1:0],
//    h = 1<<(Shift-1). q+1 if f>h, or if f==h and q[0]==1 (ties to even). q is held at
//    InWidth-Shift+1 bits, so the increment never wraps.
//  - Stage 2: clamp to [-2^(OutWidth-1), 2^(OutWidth-1)-1]. sat flag = clamp active.
//  - Stage 3: write to FIFO. Latency from DataValid_i (cycle N) to Data_o/DataValid_o, with the
//    FIFO empty, is cycle N+3. Throughput is 1 sample/clk; back-to-back valids are legal.
//  - FIFO is first-word-fall-through: Data_o = head entry while DataValid_o=1. Data_o is don't-care
//    while DataValid_o=0. A pop and a push in the same cycle are both performed, and Level_o is
//    unchanged.
//  - Full: a push with no simultaneous pop is discarded, and Dropped_o sets on that edge.
//    A push while full with a simultaneous pop is accepted.
//  - Empty: DataReady_i is ignored; no pop occurs and the pointers hold.
//  - Overflow_o sets on the edge the sat flag is written. If a set and FlagClr_i occur in the same
//    cycle, the set wins. The same rule applies to Dropped_o.
//  - Pointers are log2(D)+1 bits and wrap naturally. full = MSBs differ and the rest are equal.
//  - DataReady_i may toggle every cycle. Order is strictly preserved.
// STRUCTURE
//  - Package fir_pkg: FIR_ACC_W=48, FIR_SAMPLE_W=18, default Shift constant, and the functions
//    fir_round_conv() and fir_saturate(), which are shared with later filter blocks.
//  - Sub-module fir_sync_fifo (param Width, Depth): FWFT sync FIFO with push/pop/full/empty/level
//    and synchronous active-low reset.
//  - Top level: 2-stage round/saturate pipeline, sticky flags, FIFO instance.
// TESTING (defaults: Shift=17, OutWidth=18, D=8)
//  1. Data_i=5<<17, DataValid_i pulse at cycle N, DataReady_i=1 -> Data_o=5 with DataValid_o=1
//     at cycle N+3 only.
//  2. Rounding: (2<<17)+(1<<16) -> 2; (3<<17)+(1<<16) -> 4; (2<<17)+(1<<16)+1 -> 3;
//     -65536 -> 0; -65537 -> -1.
//  3. Saturation: 1<<40 -> 18'h1FFFF and Overflow_o=1; -(1<<40) -> 18'h20000. FlagClr_i -> 0.
//     FlagClr_i together with a new saturation -> Overflow_o stays 1.
//  4. Backpressure: DataReady_i=0, push 10 samples 1..10 -> Level_o=8, Dropped_o=1. Then raise
//     DataReady_i -> pops 1..8 in order and DataValid_o falls.
//  5. Full with pop and push in the same cycle: Level_o stays 8 and Dropped_o stays 0. The new
//     sample appears after the 7 older ones.
//  6. Rstn_i=0 for 1 cycle with 3 samples queued and 2 in the pipeline -> DataValid_o=0,
//     Level_o=0, flags 0. Next sample has latency 3.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants, types and arithmetic helpers for the FIR filter datapath.
//
// Contents
//   FIR_ACC_W          full-precision accumulator width (signed)
//   FIR_SAMPLE_W       requantized output sample width (signed)
//   FIR_DEFAULT_SHIFT  default right-shift from accumulator to sample scale
//   fir_wide_t         accumulator plus one guard bit, wide enough to hold
//                      any rounded quotient without wrapping
//   fir_round_conv()   arithmetic right shift with convergent rounding
//   fir_saturate()     clamp a wide value into a signed out_w-bit range
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_ACC_W         = 48;
    localparam int FIR_SAMPLE_W      = 18;
    localparam int FIR_DEFAULT_SHIFT = 17;

    // One guard bit above the accumulator so that rounding up the largest
    // positive quotient can never wrap into the sign bit.
    localparam int FIR_WIDE_W = FIR_ACC_W + 1;

    typedef logic signed [FIR_ACC_W-1:0]  fir_acc_t;
    typedef logic signed [FIR_WIDE_W-1:0] fir_wide_t;

    // Shift right by 'shift' and round to nearest, ties to even.
    // The discarded fraction is compared against one half of an output LSB;
    // an exact half rounds towards the even quotient, which removes the
    // small positive bias plain round-half-up would accumulate over a
    // long sample stream. A shift of zero passes the value through.
    function automatic fir_wide_t fir_round_conv(input fir_acc_t data, input int shift);
        fir_wide_t ext;
        fir_wide_t quo;
        fir_wide_t mask;
        fir_wide_t frac;
        fir_wide_t half;
        ext = {data[FIR_ACC_W-1], data};
        if (shift <= 0) begin
            return ext;
        end
        quo  = ext >>> shift;
        mask = (fir_wide_t'(1) <<< shift) - fir_wide_t'(1);
        frac = ext & mask;
        half = fir_wide_t'(1) <<< (shift - 1);
        if ((frac > half) || ((frac == half) && quo[0])) begin
            quo = quo + fir_wide_t'(1);
        end
        return quo;
    endfunction

    // Clamp a wide signed value into [-2^(out_w-1), 2^(out_w-1)-1].
    // Callers detect saturation by comparing the result with the input.
    function automatic fir_wide_t fir_saturate(input fir_wide_t value, input int out_w);
        fir_wide_t hi;
        fir_wide_t lo;
        hi = (fir_wide_t'(1) <<< (out_w - 1)) - fir_wide_t'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// ---------------------------------------------------------------------------
// fir_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always visible
// on rdata while empty is low, so a consumer can use it in the same cycle it
// decides to pop.
//
// Ports
//   clk     in   clock, all state updates on posedge
//   rst_n   in   synchronous reset, active-low (pointers only)
//   push    in   write wdata this cycle (ignored when full without a pop)
//   wdata   in   Width-bit entry to write
//   pop     in   remove the head entry (ignored when empty)
//   rdata   out  head entry, valid while empty is low
//   full    out  Depth entries stored
//   empty   out  no entries stored
//   level   out  current occupancy, 0..Depth
// ---------------------------------------------------------------------------
module fir_sync_fifo
#(
    parameter int Width = 18,
    parameter int Depth = 8
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int AW = $clog2(Depth);

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart when the address bits coincide.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [Width-1:0] mem [Depth];

    logic do_push;
    logic do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // accepted whenever it coincides with a real pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; both can advance together, leaving the level unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; stale entries are never visible
    // because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fir_output_requantizer.sv
// ---------------------------------------------------------------------------
// fir_output_requantizer
// Receive side of the FIR output interface. Each full-precision accumulator
// sample is shifted down with convergent rounding, saturated to OutWidth
// signed bits and queued in a FWFT FIFO that drives a valid/ready sink.
//
// Pipeline: stage 1 rounds, stage 2 saturates, stage 3 is the FIFO write, so
// a sample entering on cycle N is visible at the FIFO head on cycle N+3.
//
// Ports
//   Clk_i        in   clock, all logic on posedge
//   Rstn_i       in   synchronous reset, active-low
//   Data_i       in   InWidth-bit signed accumulator sample
//   DataValid_i  in   Data_i valid; always accepted (no backpressure)
//   Data_o       out  OutWidth-bit signed sample at the FIFO head
//   DataValid_o  out  FIFO not empty
//   DataReady_i  in   sink accepts the head sample this cycle
//   Overflow_o   out  sticky, some sample was clamped
//   Dropped_o    out  sticky, some sample was lost to a full FIFO
//   FlagClr_i    in   clears both sticky flags (a coincident set wins)
//   Level_o      out  FIFO occupancy
// ---------------------------------------------------------------------------
module fir_output_requantizer
    import fir_pkg::*;
#(
    parameter int InWidth   = FIR_ACC_W,
    parameter int OutWidth  = FIR_SAMPLE_W,
    parameter int Shift     = FIR_DEFAULT_SHIFT,
    parameter int FifoDepth = 8
)
(
    input  logic                         Clk_i,
    input  logic                         Rstn_i,
    input  logic [InWidth-1:0]           Data_i,
    input  logic                         DataValid_i,
    output logic [OutWidth-1:0]          Data_o,
    output logic                         DataValid_o,
    input  logic                         DataReady_i,
    output logic                         Overflow_o,
    output logic                         Dropped_o,
    input  logic                         FlagClr_i,
    output logic [$clog2(FifoDepth):0]   Level_o
);

    // Width of the rounded quotient: the shifted-out bits are gone, and one
    // extra bit absorbs the round-up of the most positive value.
    localparam int QW = InWidth - Shift + 1;

    fir_acc_t               data_ext;
    logic                   s1_valid;
    logic signed [QW-1:0]   s1_q;
    fir_wide_t              q_wide;
    fir_wide_t              q_clamped;
    logic                   sat_now;
    logic                   s2_valid;
    logic [OutWidth-1:0]    s2_data;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   drop_now;

    // Accumulator sample sign-extended to the package's native width so the
    // shared rounding helper can be used for any InWidth up to FIR_ACC_W.
    assign data_ext = FIR_ACC_W'($signed(Data_i));

    assign q_wide    = FIR_WIDE_W'(s1_q);
    assign q_clamped = fir_saturate(q_wide, OutWidth);
    assign sat_now   = s1_valid && (q_clamped != q_wide);

    // Valid bits for both pipeline stages. These are the only pipeline
    // state that is reset, which is what discards in-flight samples.
    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= DataValid_i;
            s2_valid <= s1_valid;
        end
    end

    // Pipeline data registers, enabled by the valid of the stage feeding
    // them. Left unreset since the valid bits qualify their contents.
    always_ff @(posedge Clk_i) begin
        if (DataValid_i) begin
            s1_q <= QW'(fir_round_conv(data_ext, Shift));
        end
        if (s1_valid) begin
            s2_data <= q_clamped[OutWidth-1:0];
        end
    end

    // The sink pops whenever it sees a valid head and is ready. A push that
    // meets a full FIFO with no simultaneous pop is the only way to lose a
    // sample, and that is exactly what the Dropped flag records.
    assign fifo_pop = DataValid_o && DataReady_i;
    assign drop_now = s2_valid && fifo_full && !fifo_pop;

    // Sticky status flags. Overflow is raised on the edge that captures a
    // clamped sample into stage 2; Dropped on the edge a push is discarded.
    // A new event outranks a clear in the same cycle so no event is missed.
    always_ff @(posedge Clk_i) begin
        if (!Rstn_i) begin
            Overflow_o <= 1'b0;
            Dropped_o  <= 1'b0;
        end else begin
            Overflow_o <= sat_now  || (Overflow_o && !FlagClr_i);
            Dropped_o  <= drop_now || (Dropped_o  && !FlagClr_i);
        end
    end

    fir_sync_fifo #(
        .Width (OutWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk   (Clk_i),
        .rst_n (Rstn_i),
        .push  (s2_valid),
        .wdata (s2_data),
        .pop   (fifo_pop),
        .rdata (Data_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (Level_o)
    );

    assign DataValid_o = !fifo_empty;

endmodule
